// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-lane result FIFOs drained by a round-robin
// write-back arbiter onto the common data bus.
package cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  rob_id;
        logic [31:0] rd_v;
    } cdb_entry_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int WRITE_PORTS_IN  = 4,
    parameter int WRITE_PORTS_OUT = 2,
    parameter int DEPTH_WIDTH     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  cdb_entry_t [WRITE_PORTS_IN-1:0]  result_in,
    input  logic                             flush,
    output cdb_entry_t [WRITE_PORTS_OUT-1:0] broadcast,
    output logic                             stall,
    output logic                             overflow
);
    localparam int NI = WRITE_PORTS_IN;
    localparam int NO = WRITE_PORTS_OUT;
    localparam int DW = DEPTH_WIDTH;
    localparam int PW = (NI > 1) ? $clog2(NI) : 1;
    localparam int EW = $bits(cdb_entry_t) - 1;
    localparam logic [DW:0] FULL   = {1'b1, {DW{1'b0}}};
    localparam logic [DW:0] ALMOST = FULL - 1'b1;

    logic [EW-1:0] r_mem [NI][1<<DW];
    logic [DW-1:0] r_rd  [NI];
    logic [DW-1:0] r_wr  [NI];
    logic [DW:0]   r_cnt [NI];
    logic [PW-1:0] r_rr;
    cdb_entry_t [NO-1:0] r_bc;
    logic          r_ovf;

    logic [NI-1:0] w_grant;
    logic [NI-1:0] w_push;
    logic [NI-1:0] w_wr;
    logic [PW-1:0] w_sel [NO];
    logic [NO-1:0] w_sel_v;
    logic [PW-1:0] w_lane;
    logic [PW-1:0] w_last;
    logic [PW-1:0] w_next;
    logic          w_any;
    logic          w_stall;
    int            w_n;

    // Scan from r_rr; port k takes the k-th non-empty lane found.
    always_comb begin
        w_grant = '0;
        w_sel_v = '0;
        w_any   = 1'b0;
        w_last  = '0;
        w_lane  = '0;
        w_n     = 0;
        for (int k = 0; k < NO; k++) begin
            w_sel[k] = '0;
        end
        for (int i = 0; i < NI; i++) begin
            w_lane = PW'((int'(r_rr) + i) % NI);
            if (r_cnt[w_lane] != '0 && w_n < NO) begin
                w_grant[w_lane] = 1'b1;
                for (int k = 0; k < NO; k++) begin
                    if (k == w_n) begin
                        w_sel[k]   = w_lane;
                        w_sel_v[k] = 1'b1;
                    end
                end
                w_last = w_lane;
                w_any  = 1'b1;
                w_n    = w_n + 1;
            end
        end
        w_next = PW'((int'(w_last) + 1) % NI);
    end

    // A full lane still accepts a push when its head pops that cycle.
    always_comb begin
        w_stall = flush;
        for (int l = 0; l < NI; l++) begin
            w_push[l] = result_in[l].valid & ~flush;
            w_wr[l]   = w_push[l] & ((r_cnt[l] != FULL) | w_grant[l]);
            if (r_cnt[l] >= ALMOST) begin
                w_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < NI; l++) begin
            if (w_wr[l]) begin
                r_mem[l][r_wr[l]] <= {result_in[l].rob_id, result_in[l].rd_v};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < NI; l++) begin
                r_rd[l]  <= '0;
                r_wr[l]  <= '0;
                r_cnt[l] <= '0;
            end
            r_rr  <= '0;
            r_bc  <= '0;
            r_ovf <= 1'b0;
        end else if (flush) begin
            for (int l = 0; l < NI; l++) begin
                r_rd[l]  <= '0;
                r_wr[l]  <= '0;
                r_cnt[l] <= '0;
            end
            r_rr <= '0;
            r_bc <= '0;
        end else begin
            for (int l = 0; l < NI; l++) begin
                if (w_wr[l]) begin
                    r_wr[l] <= r_wr[l] + 1'b1;
                end
                if (w_grant[l]) begin
                    r_rd[l] <= r_rd[l] + 1'b1;
                end
                if (w_wr[l] && !w_grant[l]) begin
                    r_cnt[l] <= r_cnt[l] + 1'b1;
                end else if (!w_wr[l] && w_grant[l]) begin
                    r_cnt[l] <= r_cnt[l] - 1'b1;
                end
                if (w_push[l] && !w_wr[l]) begin
                    r_ovf <= 1'b1;
                end
            end
            for (int k = 0; k < NO; k++) begin
                if (w_sel_v[k]) begin
                    r_bc[k] <= {1'b1, r_mem[w_sel[k]][r_rd[w_sel[k]]]};
                end else begin
                    r_bc[k] <= '0;
                end
            end
            if (w_any) begin
                r_rr <= w_next;
            end
        end
    end

    assign broadcast = r_bc;
    assign stall     = w_stall;
    assign overflow  = r_ovf;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios on a 2-port and a 1-port arbiter,
// checked every cycle against a queue model plus literal expectations.
`timescale 1ns/1ps
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    cdb_entry_t [3:0] res = '0;
    cdb_entry_t [1:0] bc0;
    cdb_entry_t [0:0] bc1;
    logic stall0, stall1, ovf0, ovf1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic collect = 1'b0;
    logic [5:0] lane1_q [$];

    always #5 clk = ~clk;

    cdb_arbiter #(.WRITE_PORTS_IN(4), .WRITE_PORTS_OUT(2), .DEPTH_WIDTH(2)) u_dut (
        .clk(clk), .rst(rst), .result_in(res), .flush(flush),
        .broadcast(bc0), .stall(stall0), .overflow(ovf0)
    );

    cdb_arbiter #(.WRITE_PORTS_IN(4), .WRITE_PORTS_OUT(1), .DEPTH_WIDTH(2)) u_ovf (
        .clk(clk), .rst(rst), .result_in(res), .flush(flush),
        .broadcast(bc1), .stall(stall1), .overflow(ovf1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one FIFO queue per lane (index m*4+lane).
    logic [37:0] mq [8][$];
    int          mrr [2];
    logic        mov [2];
    logic [38:0] mbc [2][2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mrr[m] = 0;
            mov[m] = 1'b0;
            mbc[m][0] = '0;
            mbc[m][1] = '0;
            for (int l = 0; l < 4; l++) mq[m*4+l].delete();
        end
    endtask

    task automatic model_step(input int m);
        int n, last, l, no;
        logic [3:0]  pop;
        logic [38:0] nb [2];
        no = (m == 0) ? 2 : 1;
        n = 0;
        last = 0;
        pop = '0;
        nb[0] = '0;
        nb[1] = '0;
        for (int i = 0; i < 4; i++) begin
            l = (mrr[m] + i) % 4;
            if (mq[m*4+l].size() > 0 && n < no) begin
                pop[l] = 1'b1;
                nb[n] = {1'b1, mq[m*4+l][0]};
                n++;
                last = l;
            end
        end
        if (flush) begin
            for (int j = 0; j < 4; j++) mq[m*4+j].delete();
            mrr[m] = 0;
            mbc[m][0] = '0;
            mbc[m][1] = '0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (pop[j]) void'(mq[m*4+j].pop_front());
                if (res[j].valid) begin
                    if (mq[m*4+j].size() < 4)
                        mq[m*4+j].push_back({res[j].rob_id, res[j].rd_v});
                    else
                        mov[m] = 1'b1;
                end
            end
            if (n > 0) mrr[m] = (last + 1) % 4;
            mbc[m][0] = nb[0];
            mbc[m][1] = nb[1];
        end
    endtask

    function automatic logic mstall(input int m);
        logic s;
        s = flush;
        for (int l = 0; l < 4; l++)
            if (mq[m*4+l].size() >= 3) s = 1'b1;
        return s;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
            end
            #1;
            chk("m0_bc0", bc0[0], mbc[0][0]);
            chk("m0_bc1", bc0[1], mbc[0][1]);
            chk("m1_bc0", bc1[0], mbc[1][0]);
            chk("m0_stall", stall0, mstall(0));
            chk("m1_stall", stall1, mstall(1));
            chk("m0_ovf", ovf0, mov[0]);
            chk("m1_ovf", ovf1, mov[1]);
            if (collect && bc1[0].valid && bc1[0].rob_id[5:4] == 2'd1)
                lane1_q.push_back(bc1[0].rob_id);
        end
    end

    task automatic drive(input logic [3:0] v, input int seq);
        for (int l = 0; l < 4; l++) begin
            res[l].valid  = v[l];
            res[l].rob_id = 6'(l * 16 + seq);
            res[l].rd_v   = 32'hA000_0000 + 32'(l * 256 + seq);
        end
    endtask

    task automatic do_reset();
        drive(4'b0000, 0);
        flush = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_lanes(input string name, input int a, input int b);
        chk({name, "_v"}, {bc0[0].valid, bc0[1].valid}, 2'b11);
        chk({name, "_p0"}, bc0[0].rob_id[5:4], a);
        chk({name, "_p1"}, bc0[1].rob_id[5:4], b);
    endtask

    initial begin
        logic       prev;
        logic [3:0] v;
        logic [5:0] e;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bc", bc0, 78'd0);
        chk("rst_stall", stall0, 1'b0);
        chk("rst_ovf", ovf0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        res[0] = {1'b1, 6'd5, 32'hDEADBEEF};
        @(negedge clk);
        drive(4'b0000, 0);
        chk("single_nobypass", bc0[0].valid, 1'b0);
        @(negedge clk);
        chk("single_bc0", bc0[0], {1'b1, 6'd5, 32'hDEADBEEF});
        chk("single_bc1_v", bc0[1].valid, 1'b0);
        repeat (3) @(negedge clk);

        do_reset();
        prev = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c >= 2 && c <= 5) begin
                if (c % 2 == 0) chk_lanes("fair", 0, 1);
                else            chk_lanes("fair", 2, 3);
            end
            if (c == 3) chk("fair_stall_lo", stall0, 1'b0);
            if (c == 4) chk("fair_stall_hi", stall0, 1'b1);
            v = prev ? 4'b0000 : 4'b1111;
            prev = stall0;
            drive(v, c + 1);
            @(negedge clk);
        end
        drive(4'b0000, 0);
        repeat (8) @(negedge clk);
        chk("fair_no_ovf", ovf0, 1'b0);

        do_reset();
        drive(4'b0011, 1);
        @(negedge clk);
        drive(4'b1010, 2);
        @(negedge clk);
        chk_lanes("rr_pre", 0, 1);
        drive(4'b1111, 3);
        @(negedge clk);
        chk_lanes("rr_skip", 3, 1);
        drive(4'b0000, 0);
        @(negedge clk);
        chk_lanes("rr_ptr2", 2, 3);
        repeat (3) @(negedge clk);

        do_reset();
        collect = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) chk("ovf_before", ovf1, 1'b0);
            drive((c == 8) ? 4'b0010 : 4'b0011, c);
            @(negedge clk);
        end
        drive(4'b0000, 0);
        chk("ovf_set", ovf1, 1'b1);
        repeat (20) @(negedge clk);
        collect = 1'b0;
        chk("ovf_sticky", ovf1, 1'b1);
        chk("ovf_count", lane1_q.size(), 7);
        for (int i = 0; i < lane1_q.size() && i < 7; i++) begin
            e = 6'(17 + i);
            chk("ovf_order", lane1_q[i], e);
        end

        do_reset();
        drive(4'b1011, 1);
        @(negedge clk);
        drive(4'b0100, 2);
        flush = 1'b1;
        #1 chk("flush_stall", stall0, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        drive(4'b0000, 0);
        chk("flush_bc", bc0, 78'd0);
        repeat (2) @(negedge clk);
        chk("flush_idle", bc0, 78'd0);
        drive(4'b1111, 3);
        @(negedge clk);
        drive(4'b0000, 0);
        @(negedge clk);
        chk_lanes("flush_rr0", 0, 1);
        repeat (3) @(negedge clk);

        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, c + 4);
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        chk("arst_bc0", bc0, 78'd0);
        chk("arst_bc1", bc1, 39'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0100, 9);
        @(negedge clk);
        drive(4'b0000, 0);
        @(negedge clk);
        chk("arst_first", bc0[0], {1'b1, 6'h29, 32'hA000_0209});
        chk("arst_bc1_v", bc0[1].valid, 1'b0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Write-back arbiter between the functional-unit stations and the common data bus. It collects completed results from `WRITE_PORTS_IN` producer lanes into per-lane FIFOs. The producer lanes are the arithmetic station's `data_out` lanes plus the other execution stations. Each cycle it drives up to `WRITE_PORTS_OUT` registered `cdb_entry_t` broadcasts, which feed the reorder buffer and the stations' `broadcast` inputs. Producers have no backpressure input, so the block buffers every result and asserts `stall` to the dispatcher before any lane can overflow.

## Interface
- `WRITE_PORTS_IN`, default 4: number of producer lanes.
- `WRITE_PORTS_OUT`, default 2: number of CDB broadcast ports per cycle; must be ≤ `WRITE_PORTS_IN`.
- `DEPTH_WIDTH`, default 2: per-lane FIFO index width. Each lane FIFO holds `DEPTH = 1 << DEPTH_WIDTH` entries.
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `result_in`  in  `cdb_entry_t[WRITE_PORTS_IN]`: completed results; a lane is pushed when `.valid` is 1.
- `flush`  in  1: synchronous pipeline flush (mispredict).
- `broadcast`  out  `cdb_entry_t[WRITE_PORTS_OUT]`: registered CDB outputs.
- `stall`  out  1: dispatch must hold.
- `overflow`  out  1: sticky error flag; an entry was dropped.

## Operation
- **Per-lane FIFO**
  - Circular buffer with `DEPTH_WIDTH`-bit read and write pointers that wrap modulo `DEPTH`.
  - A `DEPTH_WIDTH+1`-bit occupancy count, range 0..`DEPTH`.
  - A push stores `{rob_id, rd_v}`.
- **Grant**
  - Combinational round-robin from `rr_ptr` (`$clog2(WRITE_PORTS_IN)` bits).
  - Scan lanes `rr_ptr`, `rr_ptr+1`, … modulo `WRITE_PORTS_IN`.
  - Grant the first `WRITE_PORTS_OUT` non-empty lanes, at most one entry per lane per cycle.
  - Broadcast port k carries the k-th granted lane in scan order.
  - Granted lanes pop their head at the clock edge.
- **Round-robin pointer**
  - `rr_ptr` ← (index of last granted lane + 1) mod `WRITE_PORTS_IN`.
  - `rr_ptr` is unchanged when nothing is granted.
- **Broadcast register**
  - `broadcast[k]` ← granted head entry with `.valid` = 1.
  - Ports with no grant load `.valid` = 0 and all fields 0.
- **Simultaneous push and pop on one lane**
  - Both occur and the count is unchanged. This is legal even when the count equals `DEPTH`.
  - A push into an empty lane is not granted in the same cycle; there is no bypass.
- **Overflow**
  - Occurs on a push when count = `DEPTH` and the lane is not popped that cycle.
  - The new entry is dropped and the FIFO is unchanged.
  - `overflow` ← 1 and stays set until reset.
- **`stall`** (combinational)
  - 1 when any lane count ≥ `DEPTH − 1`, or when `flush` = 1.
- **Flush**
  - At the edge, all counts and pointers are cleared and `rr_ptr` ← 0.
  - All `broadcast` entries ← invalid.
  - That cycle's `result_in` is discarded and no grant is popped.
  - `overflow` is not cleared.
- **`rob_id` handling**
  - `rob_id` and `rd_v` pass through unmodified; no width conversion.
  - Duplicate `rob_id`s are not checked.

## Timing
- **Reset** (`rst` = 0, asynchronous)
  - All FIFOs empty, `rr_ptr` = 0.
  - `broadcast` = all zeros, `overflow` = 0.
  - `stall` = 0 once reset is applied.
- **Latency**
  - A result valid in cycle t is written at the end of t.
  - It is eligible for grant in t+1 and appears on `broadcast` in t+2, given no contention.
- **Throughput**
  - `WRITE_PORTS_OUT` results per cycle sustained.
  - With more active lanes than ports, each lane is granted at least once every `ceil(WRITE_PORTS_IN / WRITE_PORTS_OUT)` cycles.
- **`stall` timing**
  - `stall` follows the registered counts in the same cycle.
  - The dispatcher reacts next cycle. At most one in-flight result per lane arrives after `stall` rises, and `DEPTH − 1` guarantees room for it.
- **Reset mid-operation**
  - All state is discarded immediately.
  - Results presented while `rst` = 0 are ignored.

## Test plan
- **Single result**
  - Stimulus: reset, then lane 0 `{valid=1, rob_id=5, rd_v=0xDEADBEEF}` for one cycle.
  - Required: `broadcast[0]` = `{1, 5, 0xDEADBEEF}` exactly 2 cycles later; `broadcast[1].valid` = 0.
- **Fairness**
  - Stimulus: all 4 lanes valid every cycle for 8 cycles.
  - Required: grants alternate as lanes {0,1}, {2,3}, {0,1}, …; `stall` rises once any count reaches 3; no `overflow`.
- **Round-robin skip**
  - Stimulus: only lanes 1 and 3 hold one entry each, with `rr_ptr` = 2.
  - Required: `broadcast[0]` carries lane 3 and `broadcast[1]` carries lane 1; `rr_ptr` becomes 2.
- **Overflow**
  - Stimulus: with `WRITE_PORTS_OUT` = 1, push lanes 0 and 1 every cycle until lane 1 holds 4 entries and is not granted, then push a 5th entry to lane 1.
  - Required: `overflow` = 1 and stays set; the 5th entry is never broadcast; the earlier 4 entries are broadcast in order.
- **Flush**
  - Stimulus: assert `flush` with 3 entries buffered and a new input on lane 2.
  - Required: the next cycle `broadcast` is all invalid; nothing from before the flush is ever broadcast; `rr_ptr` = 0.
- **Async reset mid-stream**
  - Stimulus: drop `rst` to 0 mid-cycle while traffic flows.
  - Required: `broadcast` is all zeros immediately, without waiting for a clock edge; after release, the first new input is broadcast 2 cycles later.
